// File: rtl/barrett_pkg.sv
// Shared definitions for the pipelined Barrett reducer.
//   calc_mu_w / calc_r_w : width of mu and of the pre-correction remainder (K+2)
//   ctrl_state_e         : controller states (IDLE, DRAIN, DIV)
//   div_iters            : number of restoring-divider iterations for mu
package barrett_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DIV   = 2'd2
   } ctrl_state_e;

   // mu = floor(2^(2K)/q) reaches 2^(K+1) when q = 2^(K-1), hence K+2 bits.
   function automatic int calc_mu_w(input int k);
      return k + 2;
   endfunction

   // r1 lies in [0, 3q) with q < 2^K, so K+2 bits hold it without wrap.
   function automatic int calc_r_w(input int k);
      return k + 2;
   endfunction

   // One quotient bit per iteration; only the low K+2 quotient bits can be set.
   function automatic int div_iters(input int k);
      return k + 2;
   endfunction

endpackage

// File: rtl/barrett_mu_div.sv
// Sequential restoring divider computing mu = floor(2^(2K) / q).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_start   : one-cycle pulse, loads the divider and begins iterating
//   i_q       : divisor; must be held stable from i_start until o_done
//   o_done    : high during the final iteration; o_mu is valid in that cycle
//   o_mu      : quotient (K+2 bits), valid while o_done is high
module barrett_mu_div
   import barrett_pkg::*;
#(
   parameter int K = 32
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic [K-1:0] i_q,
   output logic         o_done,
   output logic [K+1:0] o_mu
);

   localparam int ITERS = div_iters(K);
   localparam int CNT_W = $clog2(ITERS + 1);

   // The dividend 2^(2K) has no set bits below position K+2, so the partial
   // remainder entering the first iteration is 2^(2K) >> (K+2) = 2^(K-2),
   // and every later iteration shifts in a zero.
   localparam logic [K:0] REM_INIT = {2'b00, 1'b1, {(K-2){1'b0}}};

   logic [K:0]       r_rem;
   logic [K:0]       r_quot;
   logic [CNT_W-1:0] r_cnt;
   logic             r_run;

   logic [K:0]       w_rem2;
   logic [K:0]       w_rem_nxt;
   logic             w_ge;
   logic [K+1:0]     w_quot_nxt;

   assign w_rem2     = r_rem << 1;
   assign w_ge       = (w_rem2 >= {1'b0, i_q});
   assign w_rem_nxt  = w_ge ? (w_rem2 - {1'b0, i_q}) : w_rem2;
   assign w_quot_nxt = {r_quot, w_ge};

   assign o_done = r_run && (r_cnt == CNT_W'(1));
   assign o_mu   = w_quot_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run  <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_quot <= '0;
      end else if (i_start) begin
         r_run  <= 1'b1;
         r_cnt  <= CNT_W'(ITERS);
         r_rem  <= REM_INIT;
         r_quot <= '0;
      end else if (r_run) begin
         r_rem  <= w_rem_nxt;
         r_quot <= w_quot_nxt[K:0];
         r_cnt  <= r_cnt - CNT_W'(1);
         if (o_done) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Pipelined Barrett modular reducer: out_r = in_x mod q, q loadable at run time.
// Three elastic stages (product, remainder estimate, correction); mu is
// produced by barrett_mu_div whenever a new legal modulus is configured.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cfg_valid/cfg_q/cfg_ready    : modulus load handshake (cfg_q[K-1] must be 1)
//   cfg_err                      : one-cycle pulse after an illegal modulus
//   busy                         : controller is draining or dividing
//   in_valid/in_x/in_ready       : 2K-bit operand handshake
//   out_valid/out_r/out_ready    : result handshake
// Build option: BARRETT_LAZY_EN -- single conditional subtraction in the
// correction stage, out_r in [0, 2q) and one bit wider to hold it.
//
// state | meaning
// IDLE  | normal operation; config and operands accepted
// DRAIN | new modulus pending; waiting for in-flight operands to leave
// DIV   | divider computing mu for the pending modulus (K+2 cycles)
module barrett_reduce_pipe
   import barrett_pkg::*;
#(
   parameter int K = 32
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_valid,
   input  logic [K-1:0]   cfg_q,
   output logic           cfg_ready,
   output logic           cfg_err,
   output logic           busy,
   input  logic           in_valid,
   input  logic [2*K-1:0] in_x,
   output logic           in_ready,
   output logic           out_valid,
`ifdef BARRETT_LAZY_EN
   output logic [K:0]     out_r,
`else
   output logic [K-1:0]   out_r,
`endif
   input  logic           out_ready
);

   localparam int MU_W = calc_mu_w(K);
   localparam int R_W  = calc_r_w(K);
   localparam int P_W  = (K + 1) + MU_W;
`ifdef BARRETT_LAZY_EN
   localparam int OUT_W = K + 1;
`else
   localparam int OUT_W = K;
`endif

   ctrl_state_e    r_state;
   ctrl_state_e    w_state_nxt;
   logic [K-1:0]   r_q_pend;
   logic [K-1:0]   r_q;
   logic [MU_W-1:0] r_mu;
   logic           r_q_ok;
   logic           r_cfg_err;

   logic           w_cfg_acc;
   logic           w_cfg_legal;
   logic           w_div_start;
   logic           w_div_done;
   logic [MU_W-1:0] w_div_mu;

   logic           r_s1_v;
   logic [R_W-1:0] r_s1_x;
   logic [P_W-1:0] r_s1_p;
   logic [K-1:0]   r_s1_q;
   logic           r_s2_v;
   logic [R_W-1:0] r_s2_r;
   logic [K-1:0]   r_s2_q;
   logic           r_s3_v;
   logic [OUT_W-1:0] r_s3_r;

   logic           w_s1_en;
   logic           w_s2_en;
   logic           w_s3_en;
   logic           w_in_acc;
   logic           w_pipe_empty;

   logic [K:0]     w_s1_q1;
   logic [P_W-1:0] w_s1_p;
   logic [R_W-1:0] w_q3;
   logic [R_W-1:0] w_q3q;
   logic [R_W-1:0] w_r1;
   logic [R_W-1:0] w_qe;
   logic [R_W-1:0] w_c1;
   logic [OUT_W-1:0] w_corr;
   logic           w_unused;

   // ---------------- controller ----------------
   assign cfg_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign cfg_err     = r_cfg_err;
   assign w_cfg_acc   = cfg_valid && cfg_ready;
   assign w_cfg_legal = cfg_q[K-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_start = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_cfg_acc && w_cfg_legal) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_pipe_empty) begin
               w_state_nxt = DIV;
               w_div_start = 1'b1;
            end
         end
         DIV: begin
            if (w_div_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_pend  <= '0;
         r_q       <= '0;
         r_mu      <= '0;
         r_q_ok    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         // Illegal moduli are consumed but leave q, mu and q_ok untouched.
         r_cfg_err <= w_cfg_acc && !w_cfg_legal;
         if (w_cfg_acc && w_cfg_legal) begin
            r_q_pend <= cfg_q;
         end
         if ((r_state == DIV) && w_div_done) begin
            r_q    <= r_q_pend;
            r_mu   <= w_div_mu;
            r_q_ok <= 1'b1;
         end
      end
   end

   barrett_mu_div #(.K(K)) u_mu_div (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_div_start),
      .i_q     (r_q_pend),
      .o_done  (w_div_done),
      .o_mu    (w_div_mu)
   );

   // ---------------- elastic pipeline ----------------
   assign w_s3_en      = !r_s3_v || out_ready;
   assign w_s2_en      = !r_s2_v || w_s3_en;
   assign w_s1_en      = !r_s1_v || w_s2_en;
   assign in_ready     = r_q_ok && (r_state == IDLE) && w_s1_en;
   assign w_in_acc     = in_valid && in_ready;
   assign w_pipe_empty = !(r_s1_v || r_s2_v || r_s3_v);

   assign out_valid = r_s3_v;
   assign out_r     = r_s3_r;

   // S1: q1 = X >> (K-1), p = q1 * mu. Each operand carries its own q so a
   // modulus change never affects work already in flight.
   assign w_s1_q1 = in_x[2*K-1:K-1];
   assign w_s1_p  = {{MU_W{1'b0}}, w_s1_q1} * {{(K+1){1'b0}}, r_mu};

   // S2: q3 = p >> (K+1); the remainder only needs K+2 bits, so both the
   // product and the subtraction are computed mod 2^(K+2).
   assign w_q3  = r_s1_p[P_W-1:K+1];
   assign w_q3q = w_q3 * {2'b00, r_s1_q};
   assign w_r1  = r_s1_x - w_q3q;

   // S3: r1 in [0, 3q) -> up to two conditional subtractions.
   assign w_qe = {2'b00, r_s2_q};
   assign w_c1 = (r_s2_r >= w_qe) ? (r_s2_r - w_qe) : r_s2_r;

`ifdef BARRETT_LAZY_EN
   assign w_corr   = w_c1[K:0];
   assign w_unused = ^{r_s1_p[K:0], w_c1[K+1]};
`else
   logic [R_W-1:0] w_c2;
   assign w_c2     = (w_c1 >= w_qe) ? (w_c1 - w_qe) : w_c1;
   assign w_corr   = w_c2[K-1:0];
   assign w_unused = ^{r_s1_p[K:0], w_c2[K+1:K]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v <= 1'b0;
         r_s1_x <= '0;
         r_s1_p <= '0;
         r_s1_q <= '0;
         r_s2_v <= 1'b0;
         r_s2_r <= '0;
         r_s2_q <= '0;
         r_s3_v <= 1'b0;
         r_s3_r <= '0;
      end else begin
         if (w_s1_en) begin
            r_s1_v <= w_in_acc;
            if (w_in_acc) begin
               r_s1_x <= in_x[R_W-1:0];
               r_s1_p <= w_s1_p;
               r_s1_q <= r_q;
            end
         end
         if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
               r_s2_r <= w_r1;
               r_s2_q <= r_s1_q;
            end
         end
         if (w_s3_en) begin
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
               r_s3_r <= w_corr;
            end
         end
      end
   end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe at K=8 (default build).
// Reference: a queue of expected residues (x mod q) pushed when an operand is
// accepted, using the modulus in force at that moment.
module tb_barrett_reduce_pipe;

   localparam int KW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic [KW-1:0] cfg_q;
   logic          cfg_ready;
   logic          cfg_err;
   logic          busy;
   logic          in_valid;
   logic [2*KW-1:0] in_x;
   logic          in_ready;
   logic          out_valid;
   logic [KW-1:0] out_r;
   logic          out_ready;

   always #5 clk = ~clk;

   barrett_reduce_pipe #(.K(KW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_q     (cfg_q),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_x      (in_x),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_r     (out_r),
      .out_ready (out_ready)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input longint unsigned obs,
                            input longint unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   longint unsigned exp_q[$];
   longint unsigned q_model = 0;
   logic            err_due = 1'b0;
   logic            hold_prev = 1'b0;
   logic [KW-1:0]   prev_r = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         q_model   = 0;
         err_due   = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check_val("sticky_valid", out_valid, 1);
            check_val("sticky_r", out_r, prev_r);
         end
         check_val("cfg_err", cfg_err, err_due);
         if (out_valid && out_ready) begin
            check_val("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_val("out_r", out_r, exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            check_val("accept_has_q", q_model != 0, 1);
            exp_q.push_back(q_model != 0 ? longint'(in_x) % q_model : 0);
         end
         err_due = cfg_valid && cfg_ready && !cfg_q[KW-1];
         if (cfg_valid && cfg_ready && cfg_q[KW-1]) q_model = cfg_q;
         hold_prev = out_valid && !out_ready;
         prev_r    = out_r;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [KW-1:0] q);
      bit rdy = 0;
      for (int k = 0; k < 100 && !rdy; k++) begin
         rdy = cfg_ready;
         if (!rdy) tick();
      end
      check_val("cfg_ready_wait", rdy, 1);
      cfg_valid = 1'b1;
      cfg_q     = q;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_cfg_done();
      bit idle = 0;
      for (int k = 0; k < 100 && !idle; k++) begin
         @(negedge clk);
         idle = !busy;
      end
      check_val("cfg_done_wait", idle, 1);
      tick();
   endtask

   task automatic send_one(input logic [2*KW-1:0] x);
      bit got = 0;
      in_valid = 1'b1;
      in_x     = x;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         if (!got) tick();
      end
      check_val("send_ready", got, 1);
      tick();
      in_valid = 1'b0;
   endtask

   // Called right after send_one: result must appear exactly 3 cycles after accept.
   task automatic expect_lat3(input string tag, input longint unsigned r);
      @(negedge clk);
      check_val({tag, "_lat1"}, out_valid, 0);
      @(negedge clk);
      check_val({tag, "_lat2"}, out_valid, 0);
      @(negedge clk);
      check_val({tag, "_lat3"}, out_valid, 1);
      check_val({tag, "_r"}, out_r, r);
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_out_valid"}, out_valid, 0);
      check_val({tag, "_out_r"}, out_r, 0);
      check_val({tag, "_in_ready"}, in_ready, 0);
      check_val({tag, "_cfg_ready"}, cfg_ready, 1);
      check_val({tag, "_cfg_err"}, cfg_err, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_q_ok"}, dut.r_q_ok, 0);
      check_val({tag, "_mu"}, dut.r_mu, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int busy_cnt;
      bit done;
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_q     = '0;
      in_valid  = 1'b0;
      in_x      = '0;
      out_ready = 1'b1;
      @(negedge clk);
      check_reset_vals("rst");
      tick();
      tick();
      rst = 1'b0;

      // No operand may enter before the first legal modulus.
      in_valid = 1'b1;
      in_x     = 16'd1234;
      repeat (3) begin
         @(negedge clk);
         check_val("pre_cfg_in_ready", in_ready, 0);
      end
      tick();
      in_valid = 1'b0;

      // q=251: DRAIN (1 cycle, empty pipe) + DIV (K+2 cycles), then ready.
      do_cfg(8'd251);
      busy_cnt = 0;
      done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         else done = 1;
      end
      check_val("busy_cycles", busy_cnt, 1 + KW + 2);
      check_val("ready_after_div", in_ready, 1);
      check_val("mu_251", dut.r_mu, (longint'(1) << (2*KW)) / 251);
      tick();

      send_one(16'd65535);
      expect_lat3("x65535", 24);

      // Back-to-back operands -> results on consecutive cycles.
      in_valid = 1'b1;
      in_x = 16'd62500; tick();
      in_x = 16'd0;     tick();
      in_x = 16'd250;   tick();
      in_valid = 1'b0;
      @(negedge clk);
      check_val("b2b0_v", out_valid, 1); check_val("b2b0_r", out_r, 1);
      @(negedge clk);
      check_val("b2b1_v", out_valid, 1); check_val("b2b1_r", out_r, 0);
      @(negedge clk);
      check_val("b2b2_v", out_valid, 1); check_val("b2b2_r", out_r, 250);
      tick();

      // q=128 gives the widest mu (2^(K+1)).
      do_cfg(8'd128);
      wait_cfg_done();
      check_val("mu_128", dut.r_mu, 512);
      send_one(16'd65535);
      expect_lat3("q128", 127);

      do_cfg(8'd251);
      wait_cfg_done();

      // Backpressure with three operands in flight.
      out_ready = 1'b0;
      send_one(16'd1000);
      send_one(16'd2000);
      send_one(16'd3000);
      repeat (5) begin
         @(negedge clk);
         check_val("bp_in_ready", in_ready, 0);
         check_val("bp_valid", out_valid, 1);
         check_val("bp_r", out_r, 247);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_val("rel0_v", out_valid, 1); check_val("rel0_r", out_r, 247);
      @(negedge clk);
      check_val("rel1_v", out_valid, 1); check_val("rel1_r", out_r, 243);
      @(negedge clk);
      check_val("rel2_v", out_valid, 1); check_val("rel2_r", out_r, 239);
      @(negedge clk);
      check_val("rel_empty", out_valid, 0);
      tick();

      // Illegal modulus is rejected, old modulus stays.
      do_cfg(8'h7F);
      @(negedge clk);
      check_val("illegal_err", cfg_err, 1);
      check_val("illegal_busy", busy, 0);
      @(negedge clk);
      check_val("illegal_err_clr", cfg_err, 0);
      check_val("illegal_mu", dut.r_mu, 261);
      tick();
      send_one(16'd65535);
      expect_lat3("after_illegal", 24);

      // Reset during cycle 4 of DIV.
      do_cfg(8'd200);
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("mid_div");
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b1;
      in_x     = 16'd4321;
      repeat (4) begin
         @(negedge clk);
         check_val("post_rst_in_ready", in_ready, 0);
      end
      tick();
      in_valid = 1'b0;
      do_cfg(8'd251);
      wait_cfg_done();
      check_val("mu_after_rst", dut.r_mu, 261);
      send_one(16'd65535);
      expect_lat3("after_rst", 24);

      // Randomised traffic with random backpressure and occasional reconfig.
      for (int c = 0; c < 600; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = $urandom_range(0, 1);
         in_x      = 16'($urandom_range(0, 65535));
         if (cfg_ready && ($urandom_range(0, 40) == 0)) begin
            cfg_valid = 1'b1;
            if ($urandom_range(0, 3) == 0) cfg_q = 8'($urandom_range(0, 127));
            else                            cfg_q = 8'($urandom_range(128, 255));
         end else begin
            cfg_valid = 1'b0;
         end
         tick();
      end
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !out_valid && !busy;
      end
      check_val("drain_left", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
